// File: rtl/uop_inertial_filter.sv
// rtl/uop_inertial_filter.sv - multi-channel clocked inertial delay / deglitch filter
// Each channel commits a new level only after it persists for the rise or fall delay.
module uop_inertial_filter #(
  parameter int WIDTH       = 4,
  parameter int RISE_DLY    = 3,
  parameter int FALL_DLY    = 5,
  parameter int SYNC_STAGES = 2,
  parameter bit INVERT      = 1'b0,
  parameter bit INIT        = 1'b0
) (
  input  logic             clk,
  input  logic             n_reset,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] busy,
  output logic [WIDTH-1:0] glitch
);

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "uop_inertial_filter: WIDTH must be at least 1");
  end
  if (RISE_DLY < 1 || RISE_DLY > 255) begin : g_bad_rise
    $fatal(1, "uop_inertial_filter: RISE_DLY must be in 1..255");
  end
  if (FALL_DLY < 1 || FALL_DLY > 255) begin : g_bad_fall
    $fatal(1, "uop_inertial_filter: FALL_DLY must be in 1..255");
  end
  if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
    $fatal(1, "uop_inertial_filter: SYNC_STAGES must be in 0..3");
  end

  // Sync flops reset to the level that matches INIT, so nothing is pending after release.
  localparam logic [WIDTH-1:0] SYNC_INIT = {WIDTH{INIT ^ INVERT}};
  localparam logic [7:0]       RISE_LAST = 8'(RISE_DLY - 1);
  localparam logic [7:0]       FALL_LAST = 8'(FALL_DLY - 1);

  logic [WIDTH-1:0] x_s;
  logic [WIDTH-1:0] t;
  logic [7:0]       cnt [WIDTH];

  if (SYNC_STAGES == 0) begin : g_nosync
    assign x_s = x;
  end else begin : g_sync
    logic [WIDTH-1:0] stage [SYNC_STAGES];

    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        for (int s = 0; s < SYNC_STAGES; s++) stage[s] <= SYNC_INIT;
      end else begin
        stage[0] <= x;
        for (int s = 1; s < SYNC_STAGES; s++) stage[s] <= stage[s-1];
      end
    end

    assign x_s = stage[SYNC_STAGES-1];
  end

  assign t = x_s ^ {WIDTH{INVERT}};

  // The delay is chosen by the committed level, so a pending rise always uses RISE_DLY.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      y      <= {WIDTH{INIT}};
      glitch <= '0;
      for (int i = 0; i < WIDTH; i++) cnt[i] <= 8'd0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        glitch[i] <= 1'b0;
        if (t[i] != y[i]) begin
          if (cnt[i] == (y[i] ? FALL_LAST : RISE_LAST)) begin
            y[i]   <= t[i];
            cnt[i] <= 8'd0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end else if (cnt[i] != 8'd0) begin
          cnt[i]    <= 8'd0;
          glitch[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < WIDTH; i++) busy[i] = (cnt[i] != 8'd0);
  end

endmodule
